cdiv_arbiter: RTL and testbench

Shares one `complex_div` instance among `NREQ` requesters, e.g. the LU engine's pivot-reciprocal path and the back-substitution/inverse engine.
- Round-robin arbitration on the issue side.
- Each issued operation's requester index is recorded in an in-order tag FIFO, so the result returns to the requester that issued it.
- Sits between the requester engines and the divider; adds zero cycles of latency on both issue and return paths.

---
 rtl/cplx_pkg.sv | 36 +++
 rtl/cdiv_arbiter_if.sv | 41 ++++
 rtl/cdiv_arbiter_tag_fifo.sv | 53 +++++
 rtl/cdiv_arbiter.sv | 137 +++++++++++++
 tb/tb_cdiv_arbiter.sv | 361 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cplx_pkg.sv
// Shared complex-arithmetic types for the divider path and its arbiter.
package cplx_pkg;

  typedef struct packed {
    logic [63:0] b;
    logic [63:0] a;
  } cplx_t;

  typedef struct packed {
    logic [63:0] b2;
    logic [63:0] a2;
    logic [63:0] b1;
    logic [63:0] a1;
  } cplx_ops_t;

  // Same bit layout as the FPU status flags {NV,DZ,OF,UF,NX}.
  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } status_t;

  typedef enum logic {
    ARB_FREE,
    ARB_LOCKED
  } arb_state_t;

  localparam logic [63:0] CPLX_ONE = 64'h3ff0000000000000;

  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/cdiv_arbiter_if.sv
// Requester and divider handshake bundle around the shared complex divider.
interface cdiv_arbiter_if
  import cplx_pkg::*;
#(
  parameter int unsigned NREQ = 4
);

  cplx_ops_t [NREQ-1:0] req_operands;
  logic      [NREQ-1:0] req_valid;
  logic      [NREQ-1:0] req_ready;

  cplx_t                rsp_result;
  status_t              rsp_status;
  logic      [NREQ-1:0] rsp_valid;
  logic      [NREQ-1:0] rsp_ready;

  cplx_ops_t            div_operands;
  logic                 div_in_valid;
  logic                 div_in_ready;
  cplx_t                div_result;
  status_t              div_status;
  logic                 div_out_valid;
  logic                 div_out_ready;

  // Arbiter side.
  modport slave (
    input  req_operands, req_valid, rsp_ready,
    input  div_in_ready, div_result, div_status, div_out_valid,
    output req_ready, rsp_result, rsp_status, rsp_valid,
    output div_operands, div_in_valid, div_out_ready
  );

  // Requester engines and divider side.
  modport master (
    output req_operands, req_valid, rsp_ready,
    output div_in_ready, div_result, div_status, div_out_valid,
    input  req_ready, rsp_result, rsp_status, rsp_valid,
    input  div_operands, div_in_valid, div_out_ready
  );

endinterface

// File: rtl/cdiv_arbiter_tag_fifo.sv
// Generic synchronous FIFO; DEPTH must be a power of two so pointers wrap naturally.
module tag_fifo #(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/cdiv_arbiter.sv
// Round-robin sharing of one complex divider among NREQ requesters; results are
// steered back to the issuing requester via an in-order tag FIFO.
module cdiv_arbiter
  import cplx_pkg::*;
#(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned DEPTH = 8
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           flush_i,
  cdiv_arbiter_if.slave  bus,
  output logic           div_flush_o,
  output logic           busy_o,
  output logic           err_o
);

  localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef logic [IDX_W-1:0] idx_t;

  arb_state_t  state_q;
  arb_state_t  state_d;
  idx_t        rr_ptr;
  idx_t        rr_ptr_d;
  idx_t        lock_idx;
  idx_t        lock_idx_d;

  idx_t        cand;
  logic        cand_found;
  int unsigned scan;
  logic        block;
  logic        issue_valid;
  logic        issue_fire;
  logic        ret_fire;
  logic        stray_ret;

  idx_t        head_tag;
  logic        fifo_full;
  logic        fifo_empty;

  assign div_flush_o = flush_i;
  assign busy_o      = !fifo_empty;
  assign block       = rst_i || flush_i;
  assign stray_ret   = bus.div_out_valid && fifo_empty;

  tag_fifo #(
    .WIDTH (IDX_W),
    .DEPTH (DEPTH)
  ) u_tag_fifo (
    .clk       (clk_i),
    .rst       (rst_i),
    .clear     (flush_i),
    .push      (issue_fire),
    .push_data (cand),
    .pop       (ret_fire),
    .head      (head_tag),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Candidate selection: a stalled grant stays locked so the operand stream
  // seen by the divider cannot change until it accepts.
  always_comb begin
    cand       = rr_ptr;
    cand_found = 1'b0;
    scan       = 0;
    if (state_q == ARB_LOCKED) begin
      cand       = lock_idx;
      cand_found = 1'b1;
    end else begin
      for (int unsigned k = 0; k < NREQ; k++) begin
        scan = (32'(rr_ptr) + k) % NREQ;
        if (!cand_found && bus.req_valid[scan]) begin
          cand_found = 1'b1;
          cand       = idx_t'(scan);
        end
      end
    end
  end

  always_comb begin
    issue_valid      = cand_found && !fifo_full && !block;
    issue_fire       = issue_valid && bus.div_in_ready;
    bus.div_in_valid = issue_valid;
    bus.div_operands = bus.req_operands[cand];
    bus.req_ready    = '0;
    if (issue_fire) begin
      bus.req_ready[cand] = 1'b1;
    end
  end

  always_comb begin
    bus.rsp_result    = bus.div_result;
    bus.rsp_status    = bus.div_status;
    bus.rsp_valid     = '0;
    bus.div_out_ready = !fifo_empty && !block && bus.rsp_ready[head_tag];
    if (bus.div_out_valid && !fifo_empty && !block) begin
      bus.rsp_valid[head_tag] = 1'b1;
    end
    ret_fire = bus.div_out_valid && bus.div_out_ready;
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr;
    lock_idx_d = lock_idx;
    if (issue_fire) begin
      state_d  = ARB_FREE;
      rr_ptr_d = idx_t'(rr_next(32'(cand), NREQ));
    end else if (issue_valid) begin
      state_d    = ARB_LOCKED;
      lock_idx_d = cand;
    end
    if (flush_i) begin
      state_d  = ARB_FREE;
      rr_ptr_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ARB_FREE;
      rr_ptr   <= '0;
      lock_idx <= '0;
      err_o    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr   <= rr_ptr_d;
      lock_idx <= lock_idx_d;
      if (stray_ret) begin
        err_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cdiv_arbiter.sv
// Scoreboard bench for cdiv_arbiter with a behavioural in-order divider model.
module tb_cdiv_arbiter;
  import cplx_pkg::*;

  localparam int unsigned NREQ  = 4;
  localparam int unsigned DEPTH = 8;

  typedef struct {
    int unsigned r;
    cplx_t       q;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  logic div_flush;
  logic busy;
  logic err;

  cdiv_arbiter_if #(.NREQ(NREQ)) bus ();

  cdiv_arbiter #(
    .NREQ  (NREQ),
    .DEPTH (DEPTH)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .flush_i     (flush),
    .bus         (bus),
    .div_flush_o (div_flush),
    .busy_o      (busy),
    .err_o       (err)
  );

  always #5 clk = ~clk;

  cplx_ops_t   ops [NREQ];
  exp_t        sb[$];
  cplx_t       pipe[$];
  int unsigned grants[$];

  logic [NREQ-1:0] valid_d;
  logic [NREQ-1:0] rspr_d;
  logic            in_ready_d;
  logic            ret_en;
  logic            stray;

  int          checks = 0;
  int          errors = 0;
  int unsigned issues = 0;
  int unsigned base;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic cplx_t cdiv(input cplx_ops_t o);
    real a1, b1, a2, b2, d;
    cplx_t q;
    a1 = $bitstoreal(o.a1);
    b1 = $bitstoreal(o.b1);
    a2 = $bitstoreal(o.a2);
    b2 = $bitstoreal(o.b2);
    d  = a2 * a2 + b2 * b2;
    q.a = $realtobits((a1 * a2 + b1 * b2) / d);
    q.b = $realtobits((b1 * a2 - a1 * b2) / d);
    return q;
  endfunction

  function automatic status_t stat_of(input cplx_t q);
    return status_t'(q.a[63:59] ^ q.b[60:56]);
  endfunction

  task automatic drive();
    bus.req_valid    = valid_d;
    for (int i = 0; i < NREQ; i++) bus.req_operands[i] = ops[i];
    bus.div_in_ready  = in_ready_d;
    bus.rsp_ready     = rspr_d;
    bus.div_out_valid = stray || (ret_en && pipe.size() != 0);
    if (pipe.size() != 0) begin
      bus.div_result = pipe[0];
      bus.div_status = stat_of(pipe[0]);
    end else begin
      bus.div_result = '0;
      bus.div_status = '0;
    end
  endtask

  task automatic monitor();
    int unsigned     r;
    exp_t            e;
    logic [NREQ-1:0] oh;
    r = 0;
    if (bus.div_in_valid && bus.div_in_ready) begin
      for (int i = 0; i < NREQ; i++) if (bus.req_ready[i]) r = i;
      chk("grant_onehot", $countones(bus.req_ready), 1);
      chk("grant_was_valid", valid_d[r], 1);
      grants.push_back(r);
      issues++;
      pipe.push_back(cdiv(bus.div_operands));
      sb.push_back('{r: r, q: cdiv(ops[r])});
    end else begin
      chk("ready_idle", bus.req_ready, 0);
    end
    if (bus.div_out_valid && bus.div_out_ready) begin
      void'(pipe.pop_front());
      if (sb.size() == 0) begin
        chk("sb_underflow", 1, 0);
      end else begin
        e  = sb.pop_front();
        oh = '0;
        oh[e.r] = 1'b1;
        chk("rsp_owner", bus.rsp_valid, oh);
        chk("rsp_result", bus.rsp_result, e.q);
        chk("rsp_status", bus.rsp_status, stat_of(e.q));
      end
    end
  endtask

  task automatic half();
    drive();
    @(negedge clk);
    monitor();
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic tick(input int unsigned n = 1);
    repeat (n) begin
      half();
      adv();
    end
  endtask

  task automatic drain();
    valid_d = '0;
    ret_en  = 1'b1;
    rspr_d  = '1;
    for (int i = 0; i < 64 && sb.size() != 0; i++) tick();
    chk("drain_left", sb.size(), 0);
    half();
    chk("drain_busy", busy, 0);
    adv();
  endtask

  task automatic issue_one(input int unsigned r);
    logic got;
    got        = 1'b0;
    valid_d    = '0;
    valid_d[r] = 1'b1;
    in_ready_d = 1'b1;
    for (int i = 0; i < 16 && !got; i++) begin
      half();
      got = bus.req_ready[r];
      adv();
    end
    chk("issue_one", got, 1);
    valid_d = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    ops[0] = '{b2: $realtobits(0.0), a2: $realtobits(2.0), b1: $realtobits(0.0), a1: CPLX_ONE};
    ops[1] = '{b2: $realtobits(1.0), a2: $realtobits(1.0), b1: $realtobits(1.0), a1: $realtobits(5.0)};
    ops[2] = '{b2: $realtobits(2.0), a2: $realtobits(1.0), b1: $realtobits(4.0), a1: $realtobits(3.0)};
    ops[3] = '{b2: $realtobits(0.0), a2: $realtobits(0.5), b1: $realtobits(2.0), a1: $realtobits(-1.0)};
    valid_d    = '1;
    rspr_d     = '1;
    in_ready_d = 1'b1;
    ret_en     = 1'b1;
    stray      = 1'b0;
    flush      = 1'b0;
    rst        = 1'b1;
    #1;

    // Reset: outputs forced quiet even with requests pending.
    half();
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_in_valid", bus.div_in_valid, 0);
    adv();
    tick();
    valid_d = '0;
    rst     = 1'b0;
    half();
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_div_flush", div_flush, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_out_ready", bus.div_out_ready, 0);
    adv();

    // Requesters 0 and 2 alternate.
    grants.delete();
    valid_d = 4'b0101;
    tick(8);
    valid_d = '0;
    for (int i = 0; i < 4; i++) chk("alt_grant", grants[i], (i % 2 == 1) ? 2 : 0);
    drain();

    // Stall with grant on requester 1, then rotation 1,2,3,0.
    flush = 1'b1;
    tick();
    flush = 1'b0;
    grants.delete();
    valid_d    = 4'b0001;
    in_ready_d = 1'b1;
    tick();
    valid_d    = '1;
    in_ready_d = 1'b0;
    repeat (3) begin
      half();
      chk("stall_operands", bus.div_operands, ops[1]);
      chk("stall_ready", bus.req_ready, 0);
      chk("stall_in_valid", bus.div_in_valid, 1);
      adv();
    end
    in_ready_d = 1'b1;
    tick(4);
    valid_d = '0;
    chk("rot_g0", grants[0], 0);
    chk("rot_g1", grants[1], 1);
    chk("rot_g2", grants[2], 2);
    chk("rot_g3", grants[3], 3);
    chk("rot_g4", grants[4], 0);
    drain();

    // Lock must hold a stalled grant when a higher-priority requester appears.
    grants.delete();
    valid_d    = 4'b1000;
    in_ready_d = 1'b0;
    half();
    chk("lock_pick", bus.div_operands, ops[3]);
    adv();
    valid_d = '1;
    repeat (2) begin
      half();
      chk("lock_hold", bus.div_operands, ops[3]);
      adv();
    end
    in_ready_d = 1'b1;
    tick();
    valid_d = '0;
    chk("lock_grant", grants[0], 3);
    drain();

    // Tag FIFO full blocks issue, even in the cycle a return pops.
    ret_en     = 1'b0;
    valid_d    = '1;
    in_ready_d = 1'b1;
    base       = issues;
    tick(8);
    chk("full_issues", issues - base, 8);
    half();
    chk("full_ready", bus.req_ready, 0);
    chk("full_in_valid", bus.div_in_valid, 0);
    chk("full_busy", busy, 1);
    adv();
    ret_en = 1'b1;
    half();
    chk("full_pop_fire", bus.div_out_valid && bus.div_out_ready, 1);
    chk("full_pop_ready", bus.req_ready, 0);
    adv();
    ret_en = 1'b0;
    half();
    chk("full_resume", $countones(bus.req_ready), 1);
    adv();
    drain();

    // Response back-pressure from the head requester.
    rspr_d = '0;
    ret_en = 1'b1;
    issue_one(1);
    issue_one(3);
    repeat (5) begin
      half();
      chk("hold_out_ready", bus.div_out_ready, 0);
      chk("hold_rsp_valid", bus.rsp_valid, 4'b0010);
      chk("hold_result", bus.rsp_result, cdiv(ops[1]));
      adv();
    end
    rspr_d = '1;
    half();
    chk("release_fire", bus.div_out_ready, 1);
    adv();
    half();
    chk("head_advance", bus.rsp_valid, 4'b1000);
    adv();
    drain();

    // Flush with three outstanding, then a stray return.
    ret_en     = 1'b0;
    valid_d    = 4'b0111;
    in_ready_d = 1'b1;
    base       = issues;
    tick(3);
    chk("fl_issues", issues - base, 3);
    ret_en = 1'b1;
    flush  = 1'b1;
    half();
    chk("fl_req_ready", bus.req_ready, 0);
    chk("fl_in_valid", bus.div_in_valid, 0);
    chk("fl_rsp_valid", bus.rsp_valid, 0);
    chk("fl_out_ready", bus.div_out_ready, 0);
    chk("fl_div_flush", div_flush, 1);
    chk("fl_busy_during", busy, 1);
    adv();
    flush = 1'b0;
    pipe.delete();
    sb.delete();
    valid_d    = '1;
    in_ready_d = 1'b0;
    half();
    chk("fl_busy_clear", busy, 0);
    chk("fl_rr_zero", bus.div_operands, ops[0]);
    adv();
    valid_d = '0;
    flush   = 1'b1;
    tick();
    flush      = 1'b0;
    in_ready_d = 1'b1;
    stray      = 1'b1;
    half();
    chk("stray_out_ready", bus.div_out_ready, 0);
    chk("stray_rsp_valid", bus.rsp_valid, 0);
    chk("stray_err_before", err, 0);
    adv();
    stray = 1'b0;
    half();
    chk("err_set", err, 1);
    adv();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick(3);
    half();
    chk("err_sticky", err, 1);
    adv();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    half();
    chk("err_cleared", err, 0);
    adv();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
